memory_arbiter: RTL

Shares a single unified memory between the processor's instruction-fetch port and data port. Both requesters use the `enable`/`busy` handshake driven by the control unit. The arbiter grants one requester at a time using round-robin priority, forwards the access to the memory, and returns read data and completion. It sits between `control_unit`/datapath and the memory, replacing separate instruction and data memories.

---
 rtl/memory_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Round-robin arbiter that shares one unified memory between the instruction-fetch
// port and the data port, using the enable/busy handshake on every side.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_NUM   = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inst_enable,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  inst_busy,
  output logic [DATA_WIDTH-1:0] inst_read_data,
  input  logic                  data_enable,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_write_data,
  input  logic [BYTE_NUM-1:0]   data_byte_write_enable,
  output logic                  data_busy,
  output logic [DATA_WIDTH-1:0] data_read_data,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [BYTE_NUM-1:0]   mem_byte_write_enable,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HIGH,
    WAIT_LOW,
    RELEASE
  } state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  inst_busy_q, inst_busy_d;
  logic                  data_busy_q, data_busy_d;
  logic [DATA_WIDTH-1:0] inst_read_data_q, inst_read_data_d;
  logic [DATA_WIDTH-1:0] data_read_data_q, data_read_data_d;
  logic                  active_d;
  logic                  granted_enable;

  assign granted_enable = grant_q ? data_enable : inst_enable;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d          = state_q;
    grant_d          = grant_q;
    last_grant_d     = last_grant_q;
    inst_read_data_d = inst_read_data_q;
    data_read_data_d = data_read_data_q;

    unique case (state_q)
      IDLE: begin
        if (inst_enable || data_enable) begin
          // On a tie the requester that did not win last time goes first.
          grant_d      = (inst_enable && data_enable) ? ~last_grant_q : data_enable;
          last_grant_d = grant_d;
          state_d      = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_HIGH;
      WAIT_HIGH: if (mem_busy) state_d = WAIT_LOW;
      WAIT_LOW: begin
        if (!mem_busy) begin
          if (grant_q) data_read_data_d = mem_read_data;
          else         inst_read_data_d = mem_read_data;
          state_d = RELEASE;
        end
      end
      RELEASE:   if (!granted_enable) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Handshake outputs are registered from the next state so they change on the edge.
    active_d     = (state_d == ISSUE) || (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
    mem_enable_d = active_d;
    inst_busy_d  = active_d && !grant_d;
    data_busy_d  = active_d && grant_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      grant_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      mem_enable_q     <= 1'b0;
      inst_busy_q      <= 1'b0;
      data_busy_q      <= 1'b0;
      // NOTE: the read-data holding registers are architecturally visible, so they are
      // reset like control state rather than left undefined.
      inst_read_data_q <= '0;
      data_read_data_q <= '0;
    end else begin
      state_q          <= state_d;
      grant_q          <= grant_d;
      last_grant_q     <= last_grant_d;
      mem_enable_q     <= mem_enable_d;
      inst_busy_q      <= inst_busy_d;
      data_busy_q      <= data_busy_d;
      inst_read_data_q <= inst_read_data_d;
      data_read_data_q <= data_read_data_d;
    end
  end

  assign mem_enable            = mem_enable_q;
  assign inst_busy             = inst_busy_q;
  assign data_busy             = data_busy_q;
  assign inst_read_data        = inst_read_data_q;
  assign data_read_data        = data_read_data_q;
  assign mem_addr              = grant_q ? data_addr : inst_addr;
  assign mem_write_data        = grant_q ? data_write_data : '0;
  // mem_enable_q is high exactly in ISSUE/WAIT_HIGH/WAIT_LOW.
  assign mem_byte_write_enable = (grant_q && mem_enable_q) ? data_byte_write_enable : '0;

endmodule
